// File: rtl/riscv_checkpoint_checker_if.sv
// Bus bundle for riscv_checkpoint_checker: table configuration, run control,
// the core signals being observed and the checker status outputs.
// master drives configuration/core signals; slave is the checker itself.
interface riscv_checkpoint_checker_if #(
  parameter int DWIDTH = 32,
  parameter int IW     = 32,
  parameter int IDX_W  = 6,
  parameter int CYC_W  = 32
);
  logic              CFG_WE;
  logic [IDX_W-1:0]  CFG_IDX;
  logic [IW-1:0]     CFG_INST;
  logic [DWIDTH-1:0] CFG_ANS;
  logic [IDX_W:0]    CFG_COUNT;
  logic              STOP_ON_FAIL;
  logic              START;
  logic [IW-1:0]     NUM_INST;
  logic [DWIDTH-1:0] OUTPUT_PORT;
  logic              HALT;
  logic              BUSY;
  logic              DONE;
  logic              PASS;
  logic              FAIL;
  logic [1:0]        FAIL_CAUSE;
  logic [IDX_W-1:0]  FAIL_IDX;
  logic [DWIDTH-1:0] FAIL_VAL;
  logic [IDX_W:0]    PASS_CNT;
  logic [IDX_W:0]    FAIL_CNT;
  logic [CYC_W-1:0]  CYCLE_CNT;

  modport master (
    output CFG_WE, CFG_IDX, CFG_INST, CFG_ANS, CFG_COUNT, STOP_ON_FAIL, START,
           NUM_INST, OUTPUT_PORT, HALT,
    input  BUSY, DONE, PASS, FAIL, FAIL_CAUSE, FAIL_IDX, FAIL_VAL,
           PASS_CNT, FAIL_CNT, CYCLE_CNT
  );

  modport slave (
    input  CFG_WE, CFG_IDX, CFG_INST, CFG_ANS, CFG_COUNT, STOP_ON_FAIL, START,
           NUM_INST, OUTPUT_PORT, HALT,
    output BUSY, DONE, PASS, FAIL, FAIL_CAUSE, FAIL_IDX, FAIL_VAL,
           PASS_CNT, FAIL_CNT, CYCLE_CNT
  );
endinterface

// File: rtl/riscv_checkpoint_checker.sv
// riscv_checkpoint_checker: compares the core's retired-instruction count and
// OUTPUT_PORT against a loadable, ascending table of checkpoints, in order,
// and reports pass / mismatch / missed / halt status.
// Optional watchdog: define CHK_TIMEOUT_EN to end a run that has not halted
// once CYCLE_CNT reaches TIMEOUT_CYC-1 (FAIL_CAUSE=3).
module riscv_checkpoint_checker #(
  parameter int NUM_CHK     = 64,
  parameter int DWIDTH      = 32,
  parameter int IW          = 32,
  parameter int IDX_W       = 6,
  parameter int CYC_W       = 32,
  parameter int TIMEOUT_CYC = 1000000
) (
  input logic CLK,
  input logic RSTn,
  riscv_checkpoint_checker_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  state_t            state_reg, state_next;
  logic [IDX_W:0]    cnt_reg, cnt_next;
  logic [IDX_W:0]    ptr_reg, ptr_next;
  logic [IDX_W:0]    pass_cnt_reg, pass_cnt_next;
  logic [IDX_W:0]    fail_cnt_reg, fail_cnt_next;
  logic [1:0]        cause_reg, cause_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [DWIDTH-1:0] val_reg, val_next;
  logic [CYC_W-1:0]  cyc_reg, cyc_next;

  // Checkpoint table (not reset) and the registered copy of entry[ptr]
  logic [IW-1:0]     tbl_inst [NUM_CHK];
  logic [DWIDTH-1:0] tbl_ans  [NUM_CHK];
  logic [IW-1:0]     ent_inst_reg;
  logic [DWIDTH-1:0] ent_ans_reg;

  logic eval, inst_eq, inst_gt, chk_ok, chk_bad;

  // Parameter sanity: the index width must address the whole table
  if (IDX_W != $clog2(NUM_CHK) || TIMEOUT_CYC < 1) begin : g_param_check
    $error("riscv_checkpoint_checker: IDX_W must equal clog2(NUM_CHK), TIMEOUT_CYC must be >= 1");
  end

  // Table write (IDLE only) and read addressed by the next pointer, so the
  // registered entry always corresponds to ptr_reg in the following cycle
  always_ff @(posedge CLK) begin
    if (bus.CFG_WE && state_reg == S_IDLE) begin
      tbl_inst[bus.CFG_IDX] <= bus.CFG_INST;
      tbl_ans[bus.CFG_IDX]  <= bus.CFG_ANS;
    end
    ent_inst_reg <= tbl_inst[ptr_next[IDX_W-1:0]];
    ent_ans_reg  <= tbl_ans[ptr_next[IDX_W-1:0]];
  end

  // State and status registers
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      ptr_reg      <= '0;
      pass_cnt_reg <= '0;
      fail_cnt_reg <= '0;
      cause_reg    <= '0;
      idx_reg      <= '0;
      val_reg      <= '0;
      cyc_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      ptr_reg      <= ptr_next;
      pass_cnt_reg <= pass_cnt_next;
      fail_cnt_reg <= fail_cnt_next;
      cause_reg    <= cause_next;
      idx_reg      <= idx_next;
      val_reg      <= val_next;
      cyc_reg      <= cyc_next;
    end
  end

  // Next-state: start, per-cycle checkpoint evaluation, halt and stop handling
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    ptr_next      = ptr_reg;
    pass_cnt_next = pass_cnt_reg;
    fail_cnt_next = fail_cnt_reg;
    cause_next    = cause_reg;
    idx_next      = idx_reg;
    val_next      = val_reg;
    cyc_next      = cyc_reg;
    eval          = 1'b0;
    inst_eq       = 1'b0;
    inst_gt       = 1'b0;
    chk_ok        = 1'b0;
    chk_bad       = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (bus.START) begin
          state_next    = S_RUN;
          cnt_next      = bus.CFG_COUNT;
          ptr_next      = '0;
          pass_cnt_next = '0;
          fail_cnt_next = '0;
          cause_next    = '0;
          idx_next      = '0;
          val_next      = '0;
          cyc_next      = '0;
        end
      end
      S_RUN: begin
        cyc_next = (&cyc_reg) ? cyc_reg : cyc_reg + 1'b1;
        eval     = (ptr_reg < cnt_reg);
        inst_eq  = (bus.NUM_INST == ent_inst_reg);
        inst_gt  = (bus.NUM_INST > ent_inst_reg);
        chk_ok   = eval && inst_eq && (bus.OUTPUT_PORT == ent_ans_reg);
        chk_bad  = eval && (inst_gt || (inst_eq && (bus.OUTPUT_PORT != ent_ans_reg)));

        if (chk_ok) begin
          pass_cnt_next = pass_cnt_reg + 1'b1;
          ptr_next      = ptr_reg + 1'b1;
        end
        if (chk_bad) begin
          fail_cnt_next = fail_cnt_reg + 1'b1;
          ptr_next      = ptr_reg + 1'b1;
          // cause_reg==0 means no failure has been recorded in this run
          if (cause_reg == 2'd0) begin
            cause_next = inst_eq ? 2'd1 : 2'd2;
            idx_next   = ptr_reg[IDX_W-1:0];
            val_next   = bus.OUTPUT_PORT;
          end
        end

        if (bus.HALT) begin
          // Everything not yet evaluated after this cycle's check is missed
          if (ptr_next < cnt_reg) begin
            fail_cnt_next = fail_cnt_next + (cnt_reg - ptr_next);
            if (cause_next == 2'd0) begin
              cause_next = 2'd2;
              idx_next   = ptr_next[IDX_W-1:0];
              val_next   = bus.OUTPUT_PORT;
            end
          end
          state_next = (fail_cnt_next == '0) ? S_PASS : S_FAIL;
        end else if (chk_bad && bus.STOP_ON_FAIL) begin
          state_next = S_FAIL;
        end
`ifdef CHK_TIMEOUT_EN
        else if (cyc_reg == CYC_W'(TIMEOUT_CYC - 1)) begin
          state_next = S_FAIL;
          if (cause_next == 2'd0) begin
            cause_next = 2'd3;
            idx_next   = ptr_next[IDX_W-1:0];
            val_next   = bus.OUTPUT_PORT;
          end
        end
`endif
      end
      default: ; // PASS/FAIL hold until reset
    endcase
  end

  assign bus.BUSY       = (state_reg == S_RUN);
  assign bus.DONE       = (state_reg == S_PASS) || (state_reg == S_FAIL);
  assign bus.PASS       = (state_reg == S_PASS);
  assign bus.FAIL       = (state_reg == S_FAIL);
  assign bus.FAIL_CAUSE = cause_reg;
  assign bus.FAIL_IDX   = idx_reg;
  assign bus.FAIL_VAL   = val_reg;
  assign bus.PASS_CNT   = pass_cnt_reg;
  assign bus.FAIL_CNT   = fail_cnt_reg;
  assign bus.CYCLE_CNT  = cyc_reg;

endmodule

// File: tb/tb_riscv_checkpoint_checker.sv
// Testbench for riscv_checkpoint_checker: directed scenarios with fixed
// expectations plus randomized runs against a behavioural checkpoint model.
module tb_riscv_checkpoint_checker;
  localparam int NUM_CHK = 64;
  localparam int DWIDTH  = 32;
  localparam int IW      = 32;
  localparam int IDX_W   = 6;
  localparam int CYC_W   = 32;
  localparam int TO      = 100;

  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  always #5 CLK = ~CLK;

  riscv_checkpoint_checker_if #(.DWIDTH(DWIDTH), .IW(IW), .IDX_W(IDX_W), .CYC_W(CYC_W)) ifc ();

  riscv_checkpoint_checker #(
    .NUM_CHK(NUM_CHK), .DWIDTH(DWIDTH), .IW(IW), .IDX_W(IDX_W),
    .CYC_W(CYC_W), .TIMEOUT_CYC(TO)
  ) dut (
    .CLK(CLK),
    .RSTn(RSTn),
    .bus(ifc)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model of one checking run
  bit          m_run, m_done, m_passed;
  int          m_cnt, m_ptr, m_pc, m_fc, m_cause, m_idx;
  logic [31:0] m_val, m_cyc;
  logic [31:0] m_inst [NUM_CHK];
  logic [31:0] m_ans  [NUM_CHK];

  function automatic void m_record(int cause, logic [31:0] out);
    if (m_cause == 0) begin
      m_cause = cause;
      m_idx   = m_ptr;
      m_val   = out;
    end
  endfunction

  function automatic void model_step();
    logic [31:0] ni, out, old_cyc;
    bit failed_now;
    failed_now = 0;
    ni  = ifc.NUM_INST;
    out = ifc.OUTPUT_PORT;
    if (!RSTn) begin
      m_run = 0; m_done = 0; m_passed = 0;
      m_cnt = 0; m_ptr = 0; m_pc = 0; m_fc = 0; m_cause = 0; m_idx = 0;
      m_val = '0; m_cyc = '0;
      return;
    end
    if (!m_run && !m_done) begin
      if (ifc.CFG_WE) begin
        m_inst[ifc.CFG_IDX] = ifc.CFG_INST;
        m_ans[ifc.CFG_IDX]  = ifc.CFG_ANS;
      end
      if (ifc.START) begin
        m_run = 1; m_cnt = int'(ifc.CFG_COUNT);
        m_ptr = 0; m_pc = 0; m_fc = 0; m_cause = 0; m_idx = 0;
        m_val = '0; m_cyc = '0;
      end
      return;
    end
    if (!m_run) return;
    old_cyc = m_cyc;
    if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
    if (m_ptr < m_cnt) begin
      if (ni == m_inst[m_ptr]) begin
        if (out == m_ans[m_ptr]) m_pc++;
        else begin m_fc++; m_record(1, out); failed_now = 1; end
        m_ptr++;
      end else if (ni > m_inst[m_ptr]) begin
        m_fc++; m_record(2, out); failed_now = 1;
        m_ptr++;
      end
    end
    if (ifc.HALT) begin
      while (m_ptr < m_cnt) begin
        m_fc++; m_record(2, out);
        m_ptr++;
      end
      m_run = 0; m_done = 1; m_passed = (m_fc == 0);
    end else if (failed_now && ifc.STOP_ON_FAIL) begin
      m_run = 0; m_done = 1; m_passed = 0;
    end
`ifdef CHK_TIMEOUT_EN
    else if (old_cyc == 32'(TO - 1)) begin
      m_record(3, out);
      m_run = 0; m_done = 1; m_passed = 0;
    end
`endif
  endfunction

  function automatic logic [89:0] obs_vec();
    return {ifc.BUSY, ifc.DONE, ifc.PASS, ifc.FAIL, ifc.FAIL_CAUSE, ifc.FAIL_IDX,
            ifc.FAIL_VAL, ifc.PASS_CNT, ifc.FAIL_CNT, ifc.CYCLE_CNT};
  endfunction

  function automatic logic [89:0] exp_vec();
    return {m_run, m_done, m_done && m_passed, m_done && !m_passed, 2'(m_cause),
            6'(m_idx), m_val, 7'(m_pc), 7'(m_fc), m_cyc};
  endfunction

  function automatic logic [31:0] ans_for(int n);
    case (n)
      4: return 32'hF00;
      6: return 32'h18;
      8: return 32'h1D;
      default: return 32'h0;
    endcase
  endfunction

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    ifc.CFG_WE = 0; ifc.CFG_IDX = '0; ifc.CFG_INST = '0; ifc.CFG_ANS = '0;
    ifc.CFG_COUNT = '0; ifc.STOP_ON_FAIL = 0; ifc.START = 0;
    ifc.NUM_INST = '0; ifc.OUTPUT_PORT = '0; ifc.HALT = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RSTn = 0;
    tick();
    RSTn = 1;
  endtask

  task automatic load_std();
    for (int e = 0; e < 3; e++) begin
      ifc.CFG_WE = 1; ifc.CFG_IDX = 6'(e);
      ifc.CFG_INST = 32'(4 + 2 * e); ifc.CFG_ANS = ans_for(4 + 2 * e);
      tick();
    end
    ifc.CFG_WE = 0;
  endtask

  task automatic start_run(int count, bit stop);
    ifc.CFG_COUNT = 7'(count); ifc.STOP_ON_FAIL = stop; ifc.START = 1;
    tick();
    ifc.START = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    RSTn = 0;
    tick(); tick();
    total++;
    if (obs_vec() !== 90'b0) begin bad++; $display("FAIL reset_outputs: got %h want 0", obs_vec()); end
    RSTn = 1;
    tick();
    total++;
    if (obs_vec() !== 90'b0) begin bad++; $display("FAIL reset_idle: got %h want 0", obs_vec()); end
    $display("[tb] reset: outputs=%h", obs_vec());
  endtask

  task automatic test_pass_run();
    do_reset(); load_std(); start_run(3, 0);
    for (int n = 0; n <= 10; n++) begin
      ifc.NUM_INST = 32'(n); ifc.OUTPUT_PORT = ans_for(n); ifc.HALT = (n == 10);
      tick();
    end
    ifc.HALT = 0;
    total++;
    if ({ifc.BUSY, ifc.DONE, ifc.PASS, ifc.FAIL} !== 4'b0110) begin
      bad++; $display("FAIL pass_status: got %b want 0110", {ifc.BUSY, ifc.DONE, ifc.PASS, ifc.FAIL});
    end
    total++;
    if ({ifc.PASS_CNT, ifc.FAIL_CNT, ifc.FAIL_CAUSE} !== {7'd3, 7'd0, 2'd0}) begin
      bad++; $display("FAIL pass_counts: got %h want %h", {ifc.PASS_CNT, ifc.FAIL_CNT, ifc.FAIL_CAUSE}, {7'd3, 7'd0, 2'd0});
    end
    $display("[tb] pass_run: pass=%0b pass_cnt=%0d", ifc.PASS, ifc.PASS_CNT);
  endtask

  task automatic test_mismatch_stop();
    do_reset(); load_std(); start_run(3, 1);
    for (int n = 0; n <= 6; n++) begin
      ifc.NUM_INST = 32'(n); ifc.OUTPUT_PORT = (n == 6) ? 32'h17 : ans_for(n);
      if (n == 6) begin
        total++;
        if (ifc.BUSY !== 1'b1) begin bad++; $display("FAIL stop_busy_before: got %b want 1", ifc.BUSY); end
      end
      tick();
    end
    total++;
    if ({ifc.BUSY, ifc.DONE, ifc.PASS, ifc.FAIL, ifc.FAIL_CAUSE, ifc.FAIL_IDX} !== {4'b0101, 2'd1, 6'd1}) begin
      bad++; $display("FAIL stop_status: got %h want %h", {ifc.BUSY, ifc.DONE, ifc.PASS, ifc.FAIL, ifc.FAIL_CAUSE, ifc.FAIL_IDX}, {4'b0101, 2'd1, 6'd1});
    end
    total++;
    if ({ifc.FAIL_VAL, ifc.PASS_CNT, ifc.FAIL_CNT} !== {32'h17, 7'd1, 7'd1}) begin
      bad++; $display("FAIL stop_capture: got %h want %h", {ifc.FAIL_VAL, ifc.PASS_CNT, ifc.FAIL_CNT}, {32'h17, 7'd1, 7'd1});
    end
    // Sticky: later HALT, matches and START must change nothing
    ifc.NUM_INST = 32'd8; ifc.OUTPUT_PORT = 32'h1D; ifc.HALT = 1; ifc.START = 1;
    tick(); tick();
    ifc.HALT = 0; ifc.START = 0;
    total++;
    if ({ifc.FAIL, ifc.BUSY, ifc.PASS_CNT, ifc.FAIL_CNT} !== {2'b10, 7'd1, 7'd1}) begin
      bad++; $display("FAIL stop_sticky: got %h want %h", {ifc.FAIL, ifc.BUSY, ifc.PASS_CNT, ifc.FAIL_CNT}, {2'b10, 7'd1, 7'd1});
    end
    $display("[tb] mismatch_stop: cause=%0d idx=%0d val=%h", ifc.FAIL_CAUSE, ifc.FAIL_IDX, ifc.FAIL_VAL);
  endtask

  task automatic test_mismatch_continue();
    do_reset(); load_std(); start_run(3, 0);
    for (int n = 0; n <= 10; n++) begin
      ifc.NUM_INST = 32'(n); ifc.OUTPUT_PORT = (n == 6) ? 32'h17 : ans_for(n);
      ifc.HALT = (n == 10);
      if (n == 10) begin
        total++;
        if (ifc.BUSY !== 1'b1) begin bad++; $display("FAIL cont_busy: got %b want 1", ifc.BUSY); end
      end
      tick();
    end
    ifc.HALT = 0;
    total++;
    if ({ifc.FAIL, ifc.PASS_CNT, ifc.FAIL_CNT, ifc.FAIL_IDX, ifc.FAIL_CAUSE} !== {1'b1, 7'd2, 7'd1, 6'd1, 2'd1}) begin
      bad++; $display("FAIL cont_result: got %h want %h", {ifc.FAIL, ifc.PASS_CNT, ifc.FAIL_CNT, ifc.FAIL_IDX, ifc.FAIL_CAUSE}, {1'b1, 7'd2, 7'd1, 6'd1, 2'd1});
    end
    $display("[tb] mismatch_continue: pass_cnt=%0d fail_cnt=%0d", ifc.PASS_CNT, ifc.FAIL_CNT);
  endtask

  task automatic test_missed();
    int seq [7] = '{0, 1, 2, 3, 4, 7, 7};
    do_reset(); load_std(); start_run(3, 0);
    for (int k = 0; k < 7; k++) begin
      ifc.NUM_INST = 32'(seq[k]); ifc.OUTPUT_PORT = (seq[k] == 7) ? 32'h77 : ans_for(seq[k]);
      ifc.HALT = (k == 6);
      tick();
    end
    ifc.HALT = 0;
    total++;
    if ({ifc.FAIL, ifc.FAIL_CAUSE, ifc.FAIL_IDX, ifc.FAIL_VAL, ifc.PASS_CNT, ifc.FAIL_CNT} !== {1'b1, 2'd2, 6'd1, 32'h77, 7'd1, 7'd2}) begin
      bad++; $display("FAIL missed_result: got %h want %h", {ifc.FAIL, ifc.FAIL_CAUSE, ifc.FAIL_IDX, ifc.FAIL_VAL, ifc.PASS_CNT, ifc.FAIL_CNT}, {1'b1, 2'd2, 6'd1, 32'h77, 7'd1, 7'd2});
    end
    $display("[tb] missed: cause=%0d idx=%0d fail_cnt=%0d", ifc.FAIL_CAUSE, ifc.FAIL_IDX, ifc.FAIL_CNT);
  endtask

  task automatic test_halt_same_cycle();
    do_reset(); load_std(); start_run(3, 1);
    for (int n = 0; n <= 8; n++) begin
      ifc.NUM_INST = 32'(n); ifc.OUTPUT_PORT = ans_for(n); ifc.HALT = (n == 8);
      tick();
    end
    ifc.HALT = 0;
    total++;
    if ({ifc.PASS, ifc.FAIL, ifc.PASS_CNT, ifc.FAIL_CNT} !== {2'b10, 7'd3, 7'd0}) begin
      bad++; $display("FAIL halt_same: got %h want %h", {ifc.PASS, ifc.FAIL, ifc.PASS_CNT, ifc.FAIL_CNT}, {2'b10, 7'd3, 7'd0});
    end
    $display("[tb] halt_same_cycle: pass=%0b pass_cnt=%0d", ifc.PASS, ifc.PASS_CNT);
  endtask

  task automatic test_reset_midrun();
    do_reset(); load_std(); start_run(3, 0);
    for (int n = 0; n <= 5; n++) begin
      ifc.NUM_INST = 32'(n); ifc.OUTPUT_PORT = ans_for(n) ^ 32'h1; tick();
    end
    RSTn = 0; tick(); RSTn = 1;
    total++;
    if (obs_vec() !== 90'b0) begin bad++; $display("FAIL midrun_reset: got %h want 0", obs_vec()); end
    // Empty table: only HALT is judged
    ifc.NUM_INST = 32'd50; start_run(0, 1);
    tick();
    total++;
    if ({ifc.BUSY, ifc.DONE, ifc.CYCLE_CNT} !== {2'b10, 32'd1}) begin
      bad++; $display("FAIL empty_busy: got %h want %h", {ifc.BUSY, ifc.DONE, ifc.CYCLE_CNT}, {2'b10, 32'd1});
    end
    ifc.HALT = 1; tick(); ifc.HALT = 0;
    total++;
    if ({ifc.PASS, ifc.FAIL, ifc.PASS_CNT, ifc.FAIL_CNT} !== {2'b10, 7'd0, 7'd0}) begin
      bad++; $display("FAIL empty_halt: got %h want %h", {ifc.PASS, ifc.FAIL, ifc.PASS_CNT, ifc.FAIL_CNT}, {2'b10, 7'd0, 7'd0});
    end
    $display("[tb] reset_midrun: outputs cleared, empty-table pass=%0b", ifc.PASS);
  endtask

  task automatic test_timeout();
    do_reset(); load_std(); start_run(3, 0);
    for (int k = 0; k < TO - 1; k++) tick();
    total++;
    if ({ifc.BUSY, ifc.CYCLE_CNT} !== {1'b1, 32'(TO - 1)}) begin
      bad++; $display("FAIL timeout_pre: got %h want %h", {ifc.BUSY, ifc.CYCLE_CNT}, {1'b1, 32'(TO - 1)});
    end
    tick();
`ifdef CHK_TIMEOUT_EN
    total++;
    if ({ifc.BUSY, ifc.FAIL, ifc.FAIL_CAUSE, ifc.FAIL_IDX, ifc.CYCLE_CNT} !== {2'b01, 2'd3, 6'd0, 32'(TO)}) begin
      bad++; $display("FAIL timeout_hit: got %h want %h", {ifc.BUSY, ifc.FAIL, ifc.FAIL_CAUSE, ifc.FAIL_IDX, ifc.CYCLE_CNT}, {2'b01, 2'd3, 6'd0, 32'(TO)});
    end
`else
    for (int k = 0; k < TO; k++) tick();
    total++;
    if ({ifc.BUSY, ifc.DONE, ifc.FAIL_CAUSE, ifc.CYCLE_CNT} !== {2'b10, 2'd0, 32'(2 * TO)}) begin
      bad++; $display("FAIL no_watchdog: got %h want %h", {ifc.BUSY, ifc.DONE, ifc.FAIL_CAUSE, ifc.CYCLE_CNT}, {2'b10, 2'd0, 32'(2 * TO)});
    end
`endif
    $display("[tb] timeout: busy=%0b cause=%0d cycles=%0d", ifc.BUSY, ifc.FAIL_CAUSE, ifc.CYCLE_CNT);
  endtask

  task automatic test_random();
    int n, len, cur;
    logic [31:0] ni;
    for (int it = 0; it < 25; it++) begin
      do_reset();
      n = $urandom_range(0, 10);
      cur = $urandom_range(1, 3);
      for (int e = 0; e < n; e++) begin
        ifc.CFG_WE = 1; ifc.CFG_IDX = 6'(e); ifc.CFG_INST = 32'(cur); ifc.CFG_ANS = $urandom;
        tick();
        cur += $urandom_range(0, 3);
      end
      ifc.CFG_WE = 0;
      start_run(n, 1'($urandom_range(0, 1)));
      len = $urandom_range(5, 40);
      ni = '0;
      for (int c = 0; c < len; c++) begin
        if (c > 0) ni += 32'($urandom_range(0, 2));
        ifc.NUM_INST = ni;
        if (m_run && m_ptr < m_cnt && ni == m_inst[m_ptr] && $urandom_range(0, 9) != 0)
          ifc.OUTPUT_PORT = m_ans[m_ptr];
        else
          ifc.OUTPUT_PORT = $urandom;
        ifc.HALT     = (c == len - 1);
        ifc.START    = ($urandom_range(0, 15) == 0);
        ifc.CFG_WE   = ($urandom_range(0, 7) == 0);
        ifc.CFG_IDX  = 6'($urandom_range(0, 9));
        ifc.CFG_INST = 32'($urandom_range(0, 50));
        ifc.CFG_ANS  = $urandom;
        tick();
        total++;
        if (obs_vec() !== exp_vec()) begin
          bad++; $display("FAIL rand_it%0d_cyc%0d: got %h want %h", it, c, obs_vec(), exp_vec());
        end
      end
      idle_inputs();
      $display("[tb] random run %0d: entries=%0d cycles=%0d pass=%0b pass_cnt=%0d fail_cnt=%0d cause=%0d",
               it, n, len, ifc.PASS, ifc.PASS_CNT, ifc.FAIL_CNT, ifc.FAIL_CAUSE);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_pass_run();
    test_mismatch_stop();
    test_mismatch_continue();
    test_missed();
    test_halt_same_cycle();
    test_reset_midrun();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_checkpoint_checker.md
Name: riscv_checkpoint_checker

Overview:
Synthesizable, parametrised self-check block for the RISCV_TOP core. It holds a loadable table of (instruction-count, expected OUTPUT_PORT) checkpoints and compares the core's NUM_INST and OUTPUT_PORT against that table in order. It reports pass, mismatch, missed-checkpoint and halt status, so checking runs on FPGA as well as in simulation. It sits beside RISCV_TOP and observes NUM_INST, OUTPUT_PORT and HALT only.

Parameters:
NUM_CHK, 64, checkpoint table depth
DWIDTH, 32, width of OUTPUT_PORT and expected value
IW, 32, width of NUM_INST and checkpoint instruction count
IDX_W, 6, index width; must equal clog2(NUM_CHK)
CYC_W, 32, cycle counter width
TIMEOUT_CYC, 1000000, watchdog limit (optional feature only)

Ports:
CLK  in  1  clock
RSTn  in  1  synchronous active-low reset
CFG_WE  in  1  table write strobe; honoured only in IDLE
CFG_IDX  in  IDX_W  table write index
CFG_INST  in  IW  checkpoint instruction count
CFG_ANS  in  DWIDTH  checkpoint expected value
CFG_COUNT  in  IDX_W+1  number of valid entries; sampled on START
STOP_ON_FAIL  in  1  1: first failure ends the run; 0: log the failure and continue
START  in  1  one-cycle pulse, IDLE->RUN
NUM_INST  in  IW  retired-instruction count from the core
OUTPUT_PORT  in  DWIDTH  core output port
HALT  in  1  core halt
BUSY  out  1  state==RUN
DONE  out  1  state is PASS or FAIL
PASS  out  1  state==PASS
FAIL  out  1  state==FAIL
FAIL_CAUSE  out  2  0 none, 1 mismatch, 2 missed, 3 timeout; first failure only
FAIL_IDX  out  IDX_W  index of first failing checkpoint
FAIL_VAL  out  DWIDTH  OUTPUT_PORT captured at first failure
PASS_CNT  out  IDX_W+1  checkpoints matched
FAIL_CNT  out  IDX_W+1  checkpoints failed (mismatch + missed)
CYCLE_CNT  out  CYC_W  cycles spent in RUN

Behaviour:
- Reset (RSTn=0 at posedge): state=IDLE; all outputs and counters 0; ptr=0. Table contents are not reset. Reset mid-run aborts the run with no status retained.
- States are IDLE, RUN, PASS, FAIL.
- IDLE: CFG_WE writes table[CFG_IDX]. CFG_WE is ignored in the other states. START latches CFG_COUNT into cnt, clears counters/ptr/FAIL_* and enters RUN next cycle. START with cnt=0 enters RUN; in that case only HALT is judged.
- RUN: CYCLE_CNT increments each cycle and saturates at all-ones. At most one checkpoint is evaluated per cycle, at index ptr, and only while ptr<cnt.
  - NUM_INST==table[ptr].inst and OUTPUT_PORT==ans: PASS_CNT++, ptr++.
  - NUM_INST==inst and OUTPUT_PORT!=ans: mismatch.
  - NUM_INST>inst (checkpoint skipped): missed.
  - Any failure: FAIL_CNT++, ptr++. The first failure records FAIL_CAUSE, FAIL_IDX=ptr and FAIL_VAL. If STOP_ON_FAIL=1, the next state is FAIL.
  - Duplicate instruction counts in consecutive entries are evaluated on successive cycles while NUM_INST holds.
  - Table entries must be ascending; behaviour with unsorted entries is undefined.
- HALT in RUN: the checkpoint evaluation of the same cycle takes effect first. Then:
  - Any entries still unevaluated (ptr<cnt after that evaluation) count as missed. FAIL_CNT increases by their number. If no failure has been recorded yet, cause=2 with FAIL_IDX=that ptr.
  - Next state is PASS if FAIL_CNT==0 after this update, else FAIL.
- When STOP_ON_FAIL=0, failures do not end the run; only HALT (or timeout) does.
- PASS/FAIL are sticky until RSTn=0. A new START returns to RUN, but only from IDLE; the sole exit from PASS/FAIL is reset.
- Comparisons are unsigned, full width. Outputs are registered: status is visible one cycle after the deciding edge.

Optional Feature:
CHK_TIMEOUT_EN
- Defined: in RUN, when CYCLE_CNT reaches TIMEOUT_CYC-1 without HALT, the next state is FAIL. FAIL_CAUSE=3 if no earlier failure; FAIL_IDX=ptr.
- Undefined: there is no watchdog, FAIL_CAUSE never equals 3, and TIMEOUT_CYC is unused.

Test Plan:
- Load 3 entries {(4,0xF00),(6,0x18),(8,0x1D)}, cnt=3, START; drive matching NUM_INST/OUTPUT_PORT, then HALT at NUM_INST=10 -> PASS=1, PASS_CNT=3, FAIL_CNT=0, FAIL_CAUSE=0.
- Same table, OUTPUT_PORT=0x17 at NUM_INST=6, STOP_ON_FAIL=1 -> FAIL=1 next cycle, FAIL_CAUSE=1, FAIL_IDX=1, FAIL_VAL=0x17, PASS_CNT=1.
- Same table with STOP_ON_FAIL=0: mismatch at index 1, rest matching, then HALT -> stays BUSY until HALT, then FAIL=1, PASS_CNT=2, FAIL_CNT=1, FAIL_IDX=1.
- NUM_INST jumps 4->7, then HALT at 7 -> index 1 missed (cause 2, FAIL_IDX=1); index 2 is counted missed at HALT; FAIL_CNT=2.
- HALT in the same cycle as a matching last checkpoint (NUM_INST=8, 0x1D) -> PASS=1, PASS_CNT=3. Assert RSTn=0 mid-run -> all outputs 0, state IDLE next cycle.
- With CHK_TIMEOUT_EN and TIMEOUT_CYC=100, no HALT -> FAIL=1 after 100 RUN cycles, FAIL_CAUSE=3. Without the macro -> still BUSY at cycle 200.
